// File: rtl/rng_rx_pkg.sv
// Shared constants and types for the RNG bit-stream receiver.
package rng_rx_pkg;

    localparam int WIDTH_DEF       = 8;
    localparam int DEPTH_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef logic [WIDTH_DEF-1:0] rng_word_t;

endpackage

// File: rtl/register.sv
// Plain W-bit register with asynchronous active-low clear.
module register #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d every clock; clear to zero on reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q <= {W{1'b0}};
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: dout shows the head entry whenever not empty.
// A push while full is accepted only if a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign dout      = mem_r[rd_ptr_r];

    // Storage array; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rng_stream_rx.sv
// Receiver for the padlock RNG 3-wire header: synchronizes the remote lines,
// captures one bit per strobe rise while done is high, packs MSB-first words
// and buffers them in an FWFT FIFO with a sticky overflow flag.
module rng_stream_rx
    import rng_rx_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     strb_in,
    input  logic                     bit_in,
    input  logic                     done_in,
    output logic [WIDTH-1:0]         word,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH);

    logic [2:0]       raw_s;
    logic [2:0]       sync_s;
    logic             strb_s;
    logic             bit_s;
    logic             done_s;
    logic             strb_s_d;
    logic             done_s_d;
    logic             rise_s;
    logic             capture_s;
    logic             done_fall_s;
    logic             last_bit_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [WIDTH-1:0] push_data_s;
    logic [WIDTH-2:0] shreg_r;
    logic [CW-1:0]    bit_cnt_r;
    logic             overflow_r;

    assign raw_s = {done_in, bit_in, strb_in};

    for (genvar g = 0; g < 3; g++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain_r;

        // Multi-flop synchronizer for one asynchronous header line.
        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                chain_r <= {SYNC_STAGES{1'b0}};
            end else begin
                chain_r <= {chain_r[SYNC_STAGES-2:0], raw_s[g]};
            end
        end

        assign sync_s[g] = chain_r[SYNC_STAGES-1];
    end

    assign strb_s = sync_s[0];
    assign bit_s  = sync_s[1];
    assign done_s = sync_s[2];

    register #(.W(1)) u_strb_d (.clk(clk), .rst_b(rst_b), .d(strb_s), .q(strb_s_d));
    register #(.W(1)) u_done_d (.clk(clk), .rst_b(rst_b), .d(done_s), .q(done_s_d));

    assign rise_s      = strb_s & ~strb_s_d;
    assign capture_s   = rise_s & done_s;
    assign done_fall_s = ~done_s & done_s_d;
    assign last_bit_s  = (bit_cnt_r == CW'(WIDTH - 1));
    assign push_data_s = {shreg_r, bit_s};
    assign push_s      = capture_s & last_bit_s;
    assign pop_s       = ~fifo_empty_s & word_ready;
    // A full FIFO only refuses the word when nothing leaves in the same cycle.
    assign drop_s      = push_s & fifo_full_s & ~pop_s;

    // Shift register and bit counter; a done fall abandons the partial word.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            shreg_r   <= {(WIDTH-1){1'b0}};
            bit_cnt_r <= {CW{1'b0}};
        end else if (done_fall_s) begin
            shreg_r   <= shreg_r;
            bit_cnt_r <= {CW{1'b0}};
        end else if (capture_s) begin
            shreg_r   <= push_data_s[WIDTH-2:0];
            bit_cnt_r <= last_bit_s ? {CW{1'b0}} : bit_cnt_r + CW'(1);
        end else begin
            shreg_r   <= shreg_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Sticky overflow flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (push_s),
        .din   (push_data_s),
        .pop   (pop_s),
        .dout  (word),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign word_valid = ~fifo_empty_s;
    assign overflow   = overflow_r;
    assign bit_cnt    = bit_cnt_r;

endmodule
